song_sequencer: RTL and testbench

- Upstream driver for the tone generator (play_note). Stores a short song in a small writable table and steps through it at a fixed tempo.
- Presents note_address/enable to the tone generator, which turns them into the speaker square wave.
- Adds an articulation gap at the end of each note so repeated notes are audibly separate. Supports one-shot and looped playback, stop, and a done pulse.

---
 rtl/song_sequencer.sv | 146 ++++++++++++++
 tb/tb_song_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Song sequencer: steps a 32-entry note table at a fixed tempo and drives the
// tone generator with note_address/enable, inserting a short silence at each note end.
module song_sequencer #(
    parameter int CLK_HZ     = 25000000,
    parameter int TICK_HZ    = 16,
    parameter int GAP_CYCLES = 125000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [6:0] wr_data,
    output logic [1:0] note_address,
    output logic       enable,
    output logic       busy,
    output logic       done,
    output logic [4:0] pos
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TW       = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW:0]   GAP_START = (TW+1)'(TICK_DIV - GAP_CYCLES);

    typedef enum logic [2:0] {IDLE, FETCH, EVAL, PLAY, FINISH} state_t;

    state_t        state, state_n;
    logic [6:0]    table_mem [32];
    logic [6:0]    rd_data;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [4:0]    remaining, rem_n;
    logic [1:0]    note_code, code_n;
    logic [4:0]    pos_n;
    logic [1:0]    na_n;
    logic          en_n, busy_n, done_n;

    // Song table: no reset, a same-cycle write/read of one address returns old data
    always_ff @(posedge clk) begin
        if (wr_en)
            table_mem[wr_addr] <= wr_data;
        if (state == FETCH)
            rd_data <= table_mem[pos];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            pos          <= '0;
            tick_cnt     <= '0;
            remaining    <= '0;
            note_code    <= '0;
            note_address <= '0;
            enable       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            pos          <= pos_n;
            tick_cnt     <= tick_n;
            remaining    <= rem_n;
            note_code    <= code_n;
            note_address <= na_n;
            enable       <= en_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        pos_n   = pos;
        tick_n  = tick_cnt;
        rem_n   = remaining;
        code_n  = note_code;
        na_n    = note_address;
        en_n    = 1'b0;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_n = FETCH;
                    pos_n   = '0;
                end
            end
            FETCH: state_n = EVAL;
            EVAL: begin
                if (rd_data[4:0] == 5'd0) begin
                    // Looping on an empty song would spin forever, so it finishes instead
                    if (loop && pos != 5'd0) begin
                        pos_n   = '0;
                        state_n = FETCH;
                    end else begin
                        state_n = FINISH;
                    end
                end else begin
                    rem_n   = rd_data[4:0];
                    tick_n  = '0;
                    code_n  = rd_data[6:5];
                    state_n = PLAY;
                end
            end
            PLAY: begin
                if (tick_cnt == TICK_LAST) begin
                    tick_n = '0;
                    if (remaining == 5'd1) begin
                        pos_n = pos + 5'd1;
                        if (pos == 5'd31 && !loop)
                            state_n = FINISH;
                        else
                            state_n = FETCH;
                    end else begin
                        rem_n = remaining - 5'd1;
                    end
                end else begin
                    tick_n = tick_cnt + TW'(1);
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (stop && state != IDLE)
            state_n = IDLE;

        // Outputs are registered, so they are derived from the upcoming state
        case (state_n)
            PLAY: begin
                na_n = code_n;
                en_n = (code_n != 2'b00) &&
                       !(rem_n == 5'd1 && {1'b0, tick_n} >= GAP_START);
            end
            FINISH: begin
                na_n   = 2'b00;
                done_n = 1'b1;
            end
            IDLE: na_n = 2'b00;
            default: ;
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed vector table for the basic song and corners,
// plus random songs checked cycle-by-cycle against a note-level playback model.
module tb_song_sequencer;

    localparam int TDIV = 10;
    localparam int GAP  = 2;
    localparam int CAP  = 500;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0, stop = 1'b0, loop = 1'b0, wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [6:0] wr_data = '0;
    logic [1:0] note_address;
    logic       enable, busy, done;
    logic [4:0] pos;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct packed {
        logic [1:0] na;
        logic       en;
        logic       busy;
        logic       done;
        logic [4:0] pos;
    } obs_t;

    typedef struct {
        logic       start;
        logic       stop;
        int         cycles;
        obs_t       exp;
        logic       chk_pos;
    } vec_t;

    logic [6:0] ref_tbl [32];
    obs_t       expq [$];
    vec_t       vecs [22];

    song_sequencer #(.CLK_HZ(100), .TICK_HZ(10), .GAP_CYCLES(2)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .loop(loop),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .note_address(note_address), .enable(enable), .busy(busy), .done(done), .pos(pos)
    );

    always #5 clk = ~clk;

    function automatic obs_t mko(logic [1:0] na, logic en, logic b, logic d, int p);
        obs_t o;
        o.na = na; o.en = en; o.busy = b; o.done = d; o.pos = 5'(p);
        return o;
    endfunction

    function automatic vec_t mkv(logic s, logic sp, int n, logic [1:0] na, logic en,
                                 logic b, logic d, logic cp, int p);
        vec_t v;
        v.start = s; v.stop = sp; v.cycles = n; v.exp = mko(na, en, b, d, p); v.chk_pos = cp;
        return v;
    endfunction

    // Expected per-cycle trace from the cycle after start: each entry costs two
    // fetch cycles then duration*TDIV play cycles, silent for the final GAP cycles.
    function automatic void build_trace(input logic lp);
        int p = 0;
        int d;
        logic [1:0] c;
        logic [1:0] prev = 2'b00;
        bit fin = 0;
        expq.delete();
        while (!fin && expq.size() < CAP) begin
            expq.push_back(mko(prev, 1'b0, 1'b1, 1'b0, p));
            expq.push_back(mko(prev, 1'b0, 1'b1, 1'b0, p));
            d = int'(ref_tbl[p][4:0]);
            c = ref_tbl[p][6:5];
            if (d == 0) begin
                if (lp && p != 0) p = 0;
                else fin = 1;
            end else begin
                for (int k = 0; k < d * TDIV; k++)
                    expq.push_back(mko(c, (c != 2'b00) && (k < d * TDIV - GAP), 1'b1, 1'b0, p));
                prev = c;
                p = (p + 1) % 32;
                if (p == 0 && !lp) fin = 1;
            end
        end
        if (fin) begin
            expq.push_back(mko(2'b00, 1'b0, 1'b1, 1'b1, p));
            expq.push_back(mko(2'b00, 1'b0, 1'b0, 1'b0, p));
        end
    endfunction

    task automatic applyStimulus(input logic st, input logic sp, input logic lp,
                                 input logic we, input logic [4:0] wa, input logic [6:0] wd);
        start = st; stop = sp; loop = lp; wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    endtask

    task automatic checkOutput(input string name, input obs_t exp, input logic chk_pos);
        obs_t got;
        got = '{na: note_address, en: enable, busy: busy, done: done, pos: pos};
        check_count++;
        if ({got.na, got.en, got.busy, got.done} == {exp.na, exp.en, exp.busy, exp.done} &&
            (!chk_pos || got.pos == exp.pos)) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s t=%0t got na=%0d en=%0b busy=%0b done=%0b pos=%0d exp na=%0d en=%0b busy=%0b done=%0b pos=%0d",
                     name, $time, got.na, got.en, got.busy, got.done, got.pos,
                     exp.na, exp.en, exp.busy, exp.done, chk_pos ? int'(exp.pos) : -1);
        end
    endtask

    task automatic write_entry(input int a, input logic [6:0] d);
        ref_tbl[a] = d;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'(a), d);
    endtask

    task automatic run_song(input string name, input logic lp, input int stop_at,
                            input int wr_at, input logic [4:0] wa, input logic [6:0] wd);
        if (wr_at >= 0) ref_tbl[wa] = wd;
        build_trace(lp);
        for (int i = 0; i < expq.size(); i++) begin
            applyStimulus(i == 0, i == stop_at, lp, i == wr_at, wa, wd);
            if (i == stop_at) begin
                checkOutput({name, "_stop"}, '0, 1'b0);
                break;
            end
            checkOutput(name, expq[i], 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 7'd0);
        checkOutput({name, "_idle"}, '0, 1'b0);
    endtask

    initial begin
        int k;
        logic lp;
        int stop_at;

        vecs[0]  = mkv(1'b0, 1'b0,  2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        vecs[1]  = mkv(1'b1, 1'b0,  1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        vecs[2]  = mkv(1'b0, 1'b0,  1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        vecs[3]  = mkv(1'b0, 1'b0, 18, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        vecs[4]  = mkv(1'b0, 1'b0,  2, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        vecs[5]  = mkv(1'b0, 1'b0,  2, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        vecs[6]  = mkv(1'b0, 1'b0,  8, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        vecs[7]  = mkv(1'b0, 1'b0,  2, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        vecs[8]  = mkv(1'b0, 1'b0,  2, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        vecs[9]  = mkv(1'b0, 1'b0, 10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        vecs[10] = mkv(1'b0, 1'b0,  2, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        vecs[11] = mkv(1'b0, 1'b0,  1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 3);
        vecs[12] = mkv(1'b0, 1'b0,  2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        vecs[13] = mkv(1'b1, 1'b1,  3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        vecs[14] = mkv(1'b1, 1'b0,  1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        vecs[15] = mkv(1'b0, 1'b0,  1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        vecs[16] = mkv(1'b0, 1'b0,  5, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        vecs[17] = mkv(1'b1, 1'b0, 13, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        vecs[18] = mkv(1'b0, 1'b0,  2, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        vecs[19] = mkv(1'b0, 1'b0,  2, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        vecs[20] = mkv(1'b0, 1'b0,  3, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1);
        vecs[21] = mkv(1'b0, 1'b1,  4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 32; i++) ref_tbl[i] = 7'd0;

        #1 resetn = 1'b0;
        #3 checkOutput("reset_async", '0, 1'b1);
        #8 resetn = 1'b1;

        write_entry(0, 7'b01_00010);
        write_entry(1, 7'b10_00001);
        write_entry(2, 7'b00_00001);
        write_entry(3, 7'b00_00000);

        // Basic song, start+stop collision, ignored restart and mid-note stop
        for (int v = 0; v < 22; v++)
            for (int c = 0; c < vecs[v].cycles; c++) begin
                applyStimulus(c == 0 ? vecs[v].start : 1'b0, c == 0 ? vecs[v].stop : 1'b0,
                              1'b0, 1'b0, 5'd0, 7'd0);
                checkOutput($sformatf("vec%0d", v), vecs[v].exp, vecs[v].chk_pos);
            end

        // Reset between edges in the middle of a note
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
        for (int c = 0; c < 7; c++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
        #3 resetn = 1'b0;
        #1 checkOutput("reset_midplay", '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 7'd0);
        #3 resetn = 1'b1;
        run_song("after_reset", 1'b0, -1, -1, 5'd0, 7'd0);

        run_song("loop_basic", 1'b1, 60, -1, 5'd0, 7'd0);
        run_song("write_during_play", 1'b0, -1, 5, 5'd1, 7'b11_00011);

        write_entry(0, 7'd0);
        run_song("empty_noloop", 1'b0, -1, -1, 5'd0, 7'd0);
        run_song("empty_loop", 1'b1, -1, -1, 5'd0, 7'd0);

        for (int i = 0; i < 32; i++) write_entry(i, 7'b11_00001);
        run_song("all32", 1'b0, -1, -1, 5'd0, 7'd0);

        for (int it = 0; it < 8; it++) begin
            k = $urandom_range(0, 5);
            for (int i = 0; i < k; i++)
                write_entry(i, {2'($urandom_range(0, 3)), 5'($urandom_range(1, 3))});
            write_entry(k, {2'($urandom_range(0, 3)), 5'd0});
            lp = 1'($urandom_range(0, 1));
            build_trace(lp);
            stop_at = (expq.size() >= CAP) ? $urandom_range(2, 150) : -1;
            run_song($sformatf("rand%0d", it), lp, stop_at, -1, 5'd0, 7'd0);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
